// File: rtl/display_sched_pkg.sv
// Shared types and constants for the display scheduler slice.
package display_sched_pkg;

    localparam int unsigned NUM_SRC_DEFAULT = 4;
    localparam logic [2:0]  SRC_ALERT       = 3'd4;
    localparam logic [2:0]  SRC_IDLE        = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_ALERT
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority grant: first requesting index at or after ptr, wrapping 3->0.
module rr_arbiter (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx
);

    logic [1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        idx       = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin seven-segment display source scheduler with a priority alert path.
module display_scheduler
    import display_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC      = NUM_SRC_DEFAULT,
    parameter int unsigned DWELL_CYCLES = 100_000_000,
    parameter int unsigned ALERT_CYCLES = 300_000_000
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [32*NUM_SRC-1:0]  src_data,
    output logic [NUM_SRC-1:0]     src_ack,
    input  logic                   alert_valid,
    input  logic [31:0]            alert_data,
    output logic                   alert_ack,
    output logic [31:0]            disp_data,
    output logic [2:0]             disp_src,
    output logic                   disp_update
);

    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] ALERT_LAST = 32'(ALERT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [1:0]          rr_q, rr_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [31:0]         data_q, data_d;
    logic [2:0]          src_q, src_d;
    logic [NUM_SRC-1:0]  src_ack_q, src_ack_d;
    logic                alert_ack_q, alert_ack_d;
    logic                upd_q, upd_d;

    logic                gnt_valid;
    logic [1:0]          gnt_idx;
    logic                src_cap;
    logic                go_idle;

    rr_arbiter u_arb (
        .req       (src_valid[3:0]),
        .ptr       (rr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q + 32'd1;
        data_d      = data_q;
        src_d       = src_q;
        src_ack_d   = '0;
        alert_ack_d = 1'b0;
        upd_d       = 1'b0;
        src_cap     = 1'b0;
        go_idle     = 1'b0;

        // Alert preempts everything, including a coincident dwell expiry.
        if (alert_valid) begin
            state_d     = ST_ALERT;
            cnt_d       = '0;
            data_d      = alert_data;
            src_d       = SRC_ALERT;
            alert_ack_d = 1'b1;
            upd_d       = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    src_cap = gnt_valid;
                end
                ST_SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        src_cap = gnt_valid;
                        go_idle = !gnt_valid;
                    end
                end
                ST_ALERT: begin
                    if (cnt_q == ALERT_LAST) begin
                        src_cap = gnt_valid;
                        go_idle = !gnt_valid;
                    end
                end
                default: begin
                    go_idle = 1'b1;
                end
            endcase

            if (src_cap) begin
                state_d            = ST_SHOW;
                cnt_d              = '0;
                data_d             = src_data[32*gnt_idx +: 32];
                src_d              = {1'b0, gnt_idx};
                src_ack_d[gnt_idx] = 1'b1;
                upd_d              = 1'b1;
                rr_d               = gnt_idx + 2'd1;
            end
            if (go_idle) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                src_d   = SRC_IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            src_q       <= SRC_IDLE;
            src_ack_q   <= '0;
            alert_ack_q <= 1'b0;
            upd_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            src_q       <= src_d;
            src_ack_q   <= src_ack_d;
            alert_ack_q <= alert_ack_d;
            upd_q       <= upd_d;
        end
    end

    assign src_ack     = src_ack_q;
    assign alert_ack   = alert_ack_q;
    assign disp_data   = data_q;
    assign disp_src    = src_q;
    assign disp_update = upd_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler with short dwell/alert periods.
module tb_display_scheduler;

    logic         clock;
    logic         resetn;
    logic [3:0]   src_valid;
    logic [127:0] src_data;
    logic [3:0]   src_ack;
    logic         alert_valid;
    logic [31:0]  alert_data;
    logic         alert_ack;
    logic [31:0]  disp_data;
    logic [2:0]   disp_src;
    logic         disp_update;

    display_scheduler #(
        .NUM_SRC      (4),
        .DWELL_CYCLES (8),
        .ALERT_CYCLES (16)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ack     (src_ack),
        .alert_valid (alert_valid),
        .alert_data  (alert_data),
        .alert_ack   (alert_ack),
        .disp_data   (disp_data),
        .disp_src    (disp_src),
        .disp_update (disp_update)
    );

    typedef struct {
        logic [2:0]  src;
        logic [31:0] data;
        int          gap;   // cycles since previous update; 0 = unchecked
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    int   last_upd = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [2:0] s, input logic [31:0] d, input int g);
        exp_t e;
        e.src  = s;
        e.data = d;
        e.gap  = g;
        sb.push_back(e);
    endtask

    // Monitor: every disp_update must match the head of the scoreboard.
    always @(negedge clock) begin
        exp_t       e;
        logic [3:0] ea;
        if (!resetn) begin
            cycle = 0;
        end else begin
            cycle++;
            chk("stray_ack", 32'(((src_ack != 4'b0) || alert_ack) && !disp_update), 32'd0);
            if (disp_update) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_update: got src %0d data %h expected none", disp_src, disp_data);
                end else begin
                    e = sb.pop_front();
                    chk("disp_src", 32'(disp_src), 32'(e.src));
                    chk("disp_data", disp_data, e.data);
                    if (e.src == 3'd4) begin
                        chk("alert_ack", 32'(alert_ack), 32'd1);
                        chk("src_ack_on_alert", 32'(src_ack), 32'd0);
                    end else begin
                        ea = 4'b0001 << e.src[1:0];
                        chk("src_ack", 32'(src_ack), 32'(ea));
                        chk("alert_ack_on_src", 32'(alert_ack), 32'd0);
                    end
                    if (e.gap != 0)
                        chk("update_gap", 32'(cycle - last_upd), 32'(e.gap));
                end
                last_upd = cycle;
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_disp_data", disp_data, 32'h0);
        chk("rst_disp_src", 32'(disp_src), 32'd7);
        chk("rst_src_ack", 32'(src_ack), 32'd0);
        chk("rst_alert_ack", 32'(alert_ack), 32'd0);
        chk("rst_disp_update", 32'(disp_update), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn      = 1'b0;
        src_valid   = 4'b0;
        alert_valid = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_outputs();
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            #2;
            if (sb.size() == 0) return;
        end
        tests++;
        fails++;
        $display("FAIL wait_empty: got %0d pending expected 0", sb.size());
    endtask

    task automatic go_idle_check(input logic [31:0] held);
        src_valid = 4'b0;
        repeat (10) @(negedge clock);
        chk("idle_src", 32'(disp_src), 32'd7);
        chk("idle_data", disp_data, held);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        src_valid   = 4'b0;
        alert_valid = 1'b0;
        alert_data  = 32'h0;
        for (int i = 0; i < 4; i++)
            src_data[32*i +: 32] = 32'hA000_0000 + 32'(i);

        // Single source capture right after reset.
        do_reset();
        src_data[31:0] = 32'h0000_0123;
        resetn    = 1'b1;
        src_valid = 4'b0001;
        push(3'd0, 32'h123, 0);
        wait_empty();
        go_idle_check(32'h123);

        // Full round robin, then drop all requests mid-dwell.
        do_reset();
        src_data[31:0] = 32'hA000_0000;
        resetn    = 1'b1;
        src_valid = 4'b1111;
        push(3'd0, 32'hA000_0000, 0);
        push(3'd1, 32'hA000_0001, 8);
        push(3'd2, 32'hA000_0002, 8);
        push(3'd3, 32'hA000_0003, 8);
        push(3'd0, 32'hA000_0000, 8);
        wait_empty();
        src_valid = 4'b0;
        repeat (7) @(negedge clock);
        chk("held_to_expiry_src", 32'(disp_src), 32'd0);
        @(negedge clock);
        chk("expired_src", 32'(disp_src), 32'd7);
        chk("expired_data", disp_data, 32'hA000_0000);
        repeat (3) @(negedge clock);

        // Alert while showing source 1; rr pointer must survive the alert.
        do_reset();
        resetn    = 1'b1;
        src_valid = 4'b0010;
        push(3'd1, 32'hA000_0001, 0);
        wait_empty();
        src_valid = 4'b0111;
        repeat (2) @(negedge clock);
        push(3'd4, 32'h00C0FFEE, 3);
        push(3'd2, 32'hA000_0002, 16);
        push(3'd0, 32'hA000_0000, 8);
        alert_data  = 32'h00C0FFEE;
        alert_valid = 1'b1;
        @(negedge clock);
        alert_valid = 1'b0;
        wait_empty();
        go_idle_check(32'hA000_0000);

        // Alert and source request together from IDLE.
        do_reset();
        resetn      = 1'b1;
        src_valid   = 4'b0100;
        alert_data  = 32'hBEEF_0002;
        alert_valid = 1'b1;
        push(3'd4, 32'hBEEF_0002, 0);
        push(3'd2, 32'hA000_0002, 16);
        @(negedge clock);
        alert_valid = 1'b0;
        wait_empty();
        go_idle_check(32'hA000_0002);

        // Reset during an alert, then a fresh grant.
        do_reset();
        resetn      = 1'b1;
        alert_data  = 32'hBEEF_0003;
        alert_valid = 1'b1;
        push(3'd4, 32'hBEEF_0003, 0);
        @(negedge clock);
        alert_valid = 1'b0;
        wait_empty();
        repeat (5) @(negedge clock);
        resetn = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clock);
        src_data[127:96] = 32'hA000_0003;
        src_valid = 4'b1000;
        resetn    = 1'b1;
        push(3'd3, 32'hA000_0003, 0);
        wait_empty();
        go_idle_check(32'hA000_0003);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
